// File: rtl/ext_arbiter_if.sv
// Request/grant and result handshake between two extension requesters, the arbiter and its consumer.
interface ext_arbiter_if;
    logic        i_req0;
    logic [15:0] i_data0;
    logic [1:0]  i_mode0;
    logic        o_gnt0;
    logic        i_req1;
    logic [15:0] i_data1;
    logic [1:0]  i_mode1;
    logic        o_gnt1;
    logic        o_valid;
    logic [31:0] o_word;
    logic        o_src;
    logic        i_ready;

    modport master (
        output i_req0, i_data0, i_mode0, i_req1, i_data1, i_mode1, i_ready,
        input  o_gnt0, o_gnt1, o_valid, o_word, o_src
    );

    modport slave (
        input  i_req0, i_data0, i_mode0, i_req1, i_data1, i_mode1, i_ready,
        output o_gnt0, o_gnt1, o_valid, o_word, o_src
    );
endinterface

// File: rtl/ext_arbiter.sv
// Two-requester arbiter feeding one shared sign/zero-extender; grant is combinational, result registered one cycle later.
// Backpressure: a held result with i_ready low blocks all grants; consume and refill can happen in the same cycle.
module ext_arbiter #(
    parameter bit FIXED_PRI = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    ext_arbiter_if.slave  bus
);
    logic        valid_q, valid_d;
    logic [31:0] word_q,  word_d;
    logic        src_q,   src_d;
    logic        ptr_q,   ptr_d;

    logic        can_accept;
    logic        win;
    logic        any_gnt;
    logic        gnt0, gnt1;
    logic [15:0] sel_data;
    logic [1:0]  sel_mode;
    logic [31:0] ext_word;

    // win only matters when some grant issues; a lone request wins outright
    always_comb begin
        can_accept = !valid_q || bus.i_ready;
        win        = 1'b0;
        if (bus.i_req0 && bus.i_req1) begin
            win = FIXED_PRI ? 1'b1 : ptr_q;
        end else begin
            win = bus.i_req1;
        end
        any_gnt = (bus.i_req0 || bus.i_req1) && can_accept && !reset;
        gnt0    = any_gnt && !win;
        gnt1    = any_gnt && win;
    end

    always_comb begin
        sel_data = win ? bus.i_data1 : bus.i_data0;
        sel_mode = win ? bus.i_mode1 : bus.i_mode0;
        ext_word = 32'h0;
        case (sel_mode)
            2'b00:   ext_word = {{16{sel_data[15]}}, sel_data};
            2'b01:   ext_word = {16'h0, sel_data};
            2'b10:   ext_word = {{24{sel_data[7]}}, sel_data[7:0]};
            default: ext_word = {24'h0, sel_data[7:0]};
        endcase
    end

    always_comb begin
        valid_d = valid_q;
        word_d  = word_q;
        src_d   = src_q;
        ptr_d   = ptr_q;
        if (any_gnt) begin
            valid_d = 1'b1;
            word_d  = ext_word;
            src_d   = win;
            ptr_d   = !win;
        end else if (bus.i_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            word_q  <= 32'h0;
            src_q   <= 1'b0;
            ptr_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            word_q  <= word_d;
            src_q   <= src_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.o_gnt0  = gnt0;
    assign bus.o_gnt1  = gnt1;
    assign bus.o_valid = valid_q;
    assign bus.o_word  = word_q;
    assign bus.o_src   = src_q;
endmodule

// File: tb/tb_ext_arbiter.sv
// Bench for ext_arbiter: round-robin and fixed-priority instances against a directed table and a random run.
module tb_ext_arbiter;
    logic clk;
    logic reset;

    ext_arbiter_if bus0 ();
    ext_arbiter_if bus1 ();

    ext_arbiter #(.FIXED_PRI(1'b0)) dut_rr (.clk(clk), .reset(reset), .bus(bus0));
    ext_arbiter #(.FIXED_PRI(1'b1)) dut_fp (.clk(clk), .reset(reset), .bus(bus1));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst;
        logic        req0;
        logic [15:0] d0;
        logic [1:0]  m0;
        logic        req1;
        logic [15:0] d1;
        logic [1:0]  m1;
        logic        rdy;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic        g0;
        logic        g1;
        logic        v;
        logic [31:0] w;
        logic        src;
        logic        cw;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    // reference state per instance (0 = round-robin, 1 = fixed priority)
    logic        m_valid [2];
    logic [31:0] m_word  [2];
    logic        m_src   [2];
    int          m_fav   [2];
    int          p_win   [2];   // -1 = no grant predicted this cycle
    stim_t       cur     [2];

    vec_t vt [20];

    function automatic logic [31:0] ext_ref(input logic [15:0] d, input logic [1:0] m);
        longint v;
        longint span;
        span = m[1] ? 256 : 65536;
        v = longint'(d) % span;
        if (!m[0] && v >= span / 2) v = v - span;
        return v[31:0];
    endfunction

    function automatic stim_t mk_s(input logic rst, input logic r0, input logic [15:0] d0,
                                   input logic [1:0] m0, input logic r1, input logic [15:0] d1,
                                   input logic [1:0] m1, input logic rdy);
        stim_t s;
        s.rst = rst; s.req0 = r0; s.d0 = d0; s.m0 = m0;
        s.req1 = r1; s.d1 = d1; s.m1 = m1; s.rdy = rdy;
        return s;
    endfunction

    function automatic vec_t mk_v(input stim_t s, input logic g0, input logic g1, input logic v,
                                  input logic [31:0] w, input logic src, input logic cw);
        vec_t r;
        r.s = s; r.g0 = g0; r.g1 = g1; r.v = v; r.w = w; r.src = src; r.cw = cw;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic int predict(input int d, input stim_t s);
        if (s.rst) return -1;
        if (m_valid[d] && !s.rdy) return -1;
        if (s.req0 && s.req1) return (d == 1) ? 1 : m_fav[d];
        if (s.req0) return 0;
        if (s.req1) return 1;
        return -1;
    endfunction

    // drive both instances at the falling edge, then check them against the model
    task automatic apply(input stim_t s0, input stim_t s1, input string tag);
        logic g0, g1;
        @(negedge clk);
        reset = s0.rst;
        bus0.i_req0 = s0.req0; bus0.i_data0 = s0.d0; bus0.i_mode0 = s0.m0;
        bus0.i_req1 = s0.req1; bus0.i_data1 = s0.d1; bus0.i_mode1 = s0.m1;
        bus0.i_ready = s0.rdy;
        bus1.i_req0 = s1.req0; bus1.i_data0 = s1.d0; bus1.i_mode0 = s1.m0;
        bus1.i_req1 = s1.req1; bus1.i_data1 = s1.d1; bus1.i_mode1 = s1.m1;
        bus1.i_ready = s1.rdy;
        cur[0] = s0;
        cur[1] = s1;
        cur[1].rst = s0.rst;
        #1;
        for (int d = 0; d < 2; d++) begin
            p_win[d] = predict(d, cur[d]);
            g0 = (d == 0) ? bus0.o_gnt0 : bus1.o_gnt0;
            g1 = (d == 0) ? bus0.o_gnt1 : bus1.o_gnt1;
            chk($sformatf("%s dut%0d gnt0", tag, d), {31'b0, g0}, {31'b0, p_win[d] == 0});
            chk($sformatf("%s dut%0d gnt1", tag, d), {31'b0, g1}, {31'b0, p_win[d] == 1});
            chk($sformatf("%s dut%0d valid", tag, d),
                {31'b0, (d == 0) ? bus0.o_valid : bus1.o_valid}, {31'b0, m_valid[d]});
            if (m_valid[d]) begin
                chk($sformatf("%s dut%0d word", tag, d),
                    (d == 0) ? bus0.o_word : bus1.o_word, m_word[d]);
                chk($sformatf("%s dut%0d src", tag, d),
                    {31'b0, (d == 0) ? bus0.o_src : bus1.o_src}, {31'b0, m_src[d]});
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (cur[d].rst) begin
                m_valid[d] = 1'b0; m_word[d] = 32'h0; m_src[d] = 1'b0; m_fav[d] = 0;
            end else if (p_win[d] >= 0) begin
                m_valid[d] = 1'b1;
                m_word[d]  = (p_win[d] == 1) ? ext_ref(cur[d].d1, cur[d].m1)
                                             : ext_ref(cur[d].d0, cur[d].m0);
                m_src[d]   = (p_win[d] == 1);
                m_fav[d]   = 1 - p_win[d];
            end else if (cur[d].rdy) begin
                m_valid[d] = 1'b0;
            end
        end
    endtask

    initial begin
        stim_t s;
        stim_t idle;
        idle = mk_s(1'b0, 1'b0, 16'h0, 2'b00, 1'b0, 16'h0, 2'b00, 1'b0);

        vt[0]  = mk_v(mk_s(1, 1, 16'h8001, 2'b00, 0, 16'h0000, 2'b00, 1), 0, 0, 0, 32'h0,        0, 1);
        vt[1]  = mk_v(mk_s(0, 1, 16'h8001, 2'b00, 0, 16'h0000, 2'b00, 1), 1, 0, 0, 32'h0,        0, 1);
        vt[2]  = mk_v(mk_s(0, 1, 16'h8001, 2'b01, 0, 16'h0000, 2'b00, 1), 1, 0, 1, 32'hFFFF8001, 0, 1);
        vt[3]  = mk_v(mk_s(0, 1, 16'h1280, 2'b10, 0, 16'h0000, 2'b00, 1), 1, 0, 1, 32'h00008001, 0, 1);
        vt[4]  = mk_v(mk_s(0, 1, 16'h1280, 2'b11, 0, 16'h0000, 2'b00, 1), 1, 0, 1, 32'hFFFFFF80, 0, 1);
        vt[5]  = mk_v(mk_s(0, 0, 16'h0000, 2'b00, 0, 16'h0000, 2'b00, 1), 0, 0, 1, 32'h00000080, 0, 1);
        vt[6]  = mk_v(mk_s(0, 0, 16'h0000, 2'b00, 0, 16'h0000, 2'b00, 1), 0, 0, 0, 32'h0,        0, 0);
        vt[7]  = mk_v(mk_s(0, 1, 16'h0012, 2'b01, 1, 16'hABCD, 2'b00, 1), 0, 1, 0, 32'h0,        0, 0);
        vt[8]  = mk_v(mk_s(0, 1, 16'h0012, 2'b01, 1, 16'hABCD, 2'b00, 1), 1, 0, 1, 32'hFFFFABCD, 1, 1);
        vt[9]  = mk_v(mk_s(0, 1, 16'h0012, 2'b01, 1, 16'hABCD, 2'b00, 1), 0, 1, 1, 32'h00000012, 0, 1);
        vt[10] = mk_v(mk_s(0, 1, 16'h0012, 2'b01, 1, 16'hABCD, 2'b00, 0), 0, 0, 1, 32'hFFFFABCD, 1, 1);
        vt[11] = mk_v(mk_s(0, 1, 16'h0012, 2'b01, 1, 16'hABCD, 2'b00, 0), 0, 0, 1, 32'hFFFFABCD, 1, 1);
        vt[12] = mk_v(mk_s(0, 1, 16'h0012, 2'b01, 1, 16'hABCD, 2'b00, 0), 0, 0, 1, 32'hFFFFABCD, 1, 1);
        vt[13] = mk_v(mk_s(0, 1, 16'h0012, 2'b01, 1, 16'hABCD, 2'b00, 1), 1, 0, 1, 32'hFFFFABCD, 1, 1);
        vt[14] = mk_v(mk_s(0, 1, 16'h0012, 2'b01, 1, 16'hABCD, 2'b00, 1), 0, 1, 1, 32'h00000012, 0, 1);
        vt[15] = mk_v(mk_s(1, 1, 16'h0012, 2'b01, 1, 16'hABCD, 2'b00, 0), 0, 0, 1, 32'hFFFFABCD, 1, 1);
        vt[16] = mk_v(mk_s(0, 1, 16'h0012, 2'b01, 1, 16'hABCD, 2'b00, 0), 1, 0, 0, 32'h0,        0, 1);
        vt[17] = mk_v(mk_s(0, 0, 16'h0000, 2'b00, 0, 16'h0000, 2'b00, 0), 0, 0, 1, 32'h00000012, 0, 1);
        vt[18] = mk_v(mk_s(0, 0, 16'h0000, 2'b00, 0, 16'h0000, 2'b00, 1), 0, 0, 1, 32'h00000012, 0, 1);
        vt[19] = mk_v(mk_s(0, 0, 16'h0000, 2'b00, 0, 16'h0000, 2'b00, 1), 0, 0, 0, 32'h0,        0, 0);

        // initial reset before anything is compared
        reset = 1'b1;
        bus0.i_req0 = 0; bus0.i_data0 = 0; bus0.i_mode0 = 0;
        bus0.i_req1 = 0; bus0.i_data1 = 0; bus0.i_mode1 = 0; bus0.i_ready = 0;
        bus1.i_req0 = 0; bus1.i_data0 = 0; bus1.i_mode0 = 0;
        bus1.i_req1 = 0; bus1.i_data1 = 0; bus1.i_mode1 = 0; bus1.i_ready = 0;
        repeat (2) @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            m_valid[d] = 1'b0; m_word[d] = 32'h0; m_src[d] = 1'b0; m_fav[d] = 0; p_win[d] = -1;
        end

        // directed table against the round-robin instance
        for (int i = 0; i < 20; i++) begin
            apply(vt[i].s, vt[i].s, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d tbl gnt0", i),  {31'b0, bus0.o_gnt0},  {31'b0, vt[i].g0});
            chk($sformatf("vec%0d tbl gnt1", i),  {31'b0, bus0.o_gnt1},  {31'b0, vt[i].g1});
            chk($sformatf("vec%0d tbl valid", i), {31'b0, bus0.o_valid}, {31'b0, vt[i].v});
            if (vt[i].cw) begin
                chk($sformatf("vec%0d tbl word", i), bus0.o_word, vt[i].w);
                chk($sformatf("vec%0d tbl src", i),  {31'b0, bus0.o_src}, {31'b0, vt[i].src});
            end
            advance();
        end

        // fixed priority: requester 1 always wins, requester 0 only once it drops
        s = mk_s(0, 1, 16'h00F0, 2'b10, 1, 16'h7FFF, 2'b00, 1);
        for (int i = 0; i < 4; i++) begin
            apply(s, s, $sformatf("fp%0d", i));
            chk($sformatf("fp%0d gnt1", i), {31'b0, bus1.o_gnt1}, 32'd1);
            chk($sformatf("fp%0d gnt0", i), {31'b0, bus1.o_gnt0}, 32'd0);
            if (i > 0) chk($sformatf("fp%0d word", i), bus1.o_word, 32'h00007FFF);
            advance();
        end
        s.req1 = 1'b0;
        apply(s, s, "fp_drop");
        chk("fp_drop gnt0", {31'b0, bus1.o_gnt0}, 32'd1);
        advance();
        apply(idle, idle, "fp_tail");
        chk("fp_tail word", bus1.o_word, 32'hFFFFFFF0);
        chk("fp_tail src",  {31'b0, bus1.o_src}, 32'd0);
        advance();

        // random run: requests held until granted, occasional reset
        cur[0] = idle;
        cur[1] = idle;
        for (int n = 0; n < 3000; n++) begin
            stim_t r [2];
            logic rst;
            rst = ($urandom_range(0, 63) == 0);
            for (int d = 0; d < 2; d++) begin
                r[d] = cur[d];
                r[d].rst = rst;
                if (!r[d].req0 && $urandom_range(0, 1) == 1) begin
                    r[d].req0 = 1'b1; r[d].d0 = 16'($urandom); r[d].m0 = 2'($urandom);
                end
                if (!r[d].req1 && $urandom_range(0, 1) == 1) begin
                    r[d].req1 = 1'b1; r[d].d1 = 16'($urandom); r[d].m1 = 2'($urandom);
                end
                r[d].rdy = ($urandom_range(0, 3) != 0);
            end
            apply(r[0], r[1], $sformatf("rnd%0d", n));
            advance();
            for (int d = 0; d < 2; d++) begin
                if (p_win[d] == 0) cur[d].req0 = 1'b0;
                if (p_win[d] == 1) cur[d].req1 = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
